// File: rtl/ps2_scan_rx_if.sv
// Key-code output bus of the PS/2 receiver: held code plus its two event strobes.
interface ps2_scan_rx_if;
  logic [8:0] data;
  logic       ready;
  logic       frame_err;

  modport master (output data, output ready, output frame_err);
  modport slave  (input  data, input  ready, input  frame_err);
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the pad lines, deframes 11-bit frames
// and folds E0/F0 prefixes into a held 9-bit key code {ext, code}.
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int TO_W       = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_scan_rx_if.master  rx
);

  localparam int FL_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FL_W-1:0] FL_LAST    = FL_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Two-flop synchronisers for {ps2_data, ps2_clk}; idle level of both lines is high.
  logic [1:0] pad_in;
  logic [1:0] pad_sync;
  assign pad_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pad_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pad_sync[gi] = sync_reg;
    end
  endgenerate

  logic sync_clk;
  logic sync_data;
  assign sync_clk  = pad_sync[0];
  assign sync_data = pad_sync[1];

  logic            filt_reg,      filt_next;
  logic [FL_W-1:0] flt_cnt_reg,   flt_cnt_next;
  logic [1:0]      state_reg,     state_next;
  logic [2:0]      bit_cnt_reg,   bit_cnt_next;
  logic [7:0]      shift_reg,     shift_next;
  logic            parity_reg,    parity_next;
  logic [TO_W-1:0] to_cnt_reg,    to_cnt_next;
  logic            rx_done_reg,   rx_done_next;
  logic            rx_ok_reg,     rx_ok_next;
  logic            ext_reg,       ext_next;
  logic            brk_reg,       brk_next;
  logic [8:0]      data_reg,      data_next;
  logic            ready_reg,     ready_next;
  logic            frame_err_reg, frame_err_next;
  logic            fall;

  always_comb begin
    filt_next      = filt_reg;
    flt_cnt_next   = flt_cnt_reg;
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    to_cnt_next    = to_cnt_reg;
    rx_done_next   = 1'b0;
    rx_ok_next     = rx_ok_reg;
    ext_next       = ext_reg;
    brk_next       = brk_reg;
    data_next      = data_reg;
    ready_next     = 1'b0;
    frame_err_next = 1'b0;
    fall           = 1'b0;

    // Accept a new clock level only after FILTER_LEN consecutive cycles at that level.
    if (sync_clk != filt_reg) begin
      if (flt_cnt_reg == FL_LAST) begin
        filt_next    = sync_clk;
        flt_cnt_next = '0;
        fall         = filt_reg;
      end else begin
        flt_cnt_next = flt_cnt_reg + FL_W'(1);
      end
    end else begin
      flt_cnt_next = '0;
    end

    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!sync_data) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {sync_data, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = sync_data;
          state_next  = STOP;
        end
        default: begin
          state_next   = IDLE;
          rx_done_next = 1'b1;
          rx_ok_next   = sync_data && ((^shift_reg ^ parity_reg) == 1'b1);
        end
      endcase
    end

    // A stalled frame is abandoned along with any prefix context it carried.
    if (fall || state_reg == IDLE) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg == TO_LIMIT) begin
      to_cnt_next    = '0;
      state_next     = IDLE;
      frame_err_next = 1'b1;
      ext_next       = 1'b0;
      brk_next       = 1'b0;
    end else begin
      to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    // The shift register still holds the finished byte: the next frame has not started yet.
    if (rx_done_reg) begin
      if (!rx_ok_reg) begin
        frame_err_next = 1'b1;
      end else if (shift_reg == CODE_EXT) begin
        ext_next = 1'b1;
      end else if (shift_reg == CODE_BRK) begin
        brk_next = 1'b1;
      end else begin
        if (!brk_reg) begin
          data_next  = {ext_reg, shift_reg};
          ready_next = 1'b1;
        end else if ({ext_reg, shift_reg} == data_reg) begin
          data_next = 9'h000;
        end
        ext_next = 1'b0;
        brk_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_reg      <= 1'b1;
      flt_cnt_reg   <= '0;
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      rx_done_reg   <= 1'b0;
      rx_ok_reg     <= 1'b0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      data_reg      <= 9'h000;
      ready_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      filt_reg      <= filt_next;
      flt_cnt_reg   <= flt_cnt_next;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      to_cnt_reg    <= to_cnt_next;
      rx_done_reg   <= rx_done_next;
      rx_ok_reg     <= rx_ok_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      data_reg      <= data_next;
      ready_reg     <= ready_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign rx.data      = data_reg;
  assign rx.ready     = ready_reg;
  assign rx.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench: a keyboard-level model predicts each ready/frame_err event, a monitor consumes them.
module tb_ps2_scan_rx;
  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int TOW  = 10;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scan_rx_if bus();

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .TO_W(TOW)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [8:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Keyboard-level model: held key code and pending prefixes.
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  logic [8:0] m_data = 9'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_brk) begin
        m_data = {m_ext, b};
        sb.push_back('{1'b0, m_data});
      end else if ({m_ext, b} == m_data) begin
        m_data = 9'h000;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      wait_cycles(1);
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    logic p;
    p = (~^b) ^ bad_par;
    if (bad_par || bad_stop) sb.push_back('{1'b1, m_data});
    else model_byte(b);
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    wait_cycles(HALF);
    ps2_data = 1'b1;
    check({"pending ", tag}, sb.size(), 0);
    check({"data ", tag}, {23'd0, bus.data}, {23'd0, m_data});
  endtask

  always @(negedge clk) begin
    if (rst && (bus.ready || bus.frame_err)) begin
      tests++;
      if (bus.ready && bus.frame_err) begin
        fails++;
        $display("[TB] FAIL overlap: ready=1 frame_err=1, required not both");
      end else if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected event: ready=%0b frame_err=%0b data=%h, none required",
                 bus.ready, bus.frame_err, bus.data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err != bus.frame_err || bus.data !== mon_e.val) begin
          fails++;
          $display("[TB] FAIL event: frame_err=%0b data=%h, required frame_err=%0b data=%h",
                   bus.frame_err, bus.data, mon_e.is_err, mon_e.val);
        end else begin
          $display("[TB] ok   event %s data=%h", mon_e.is_err ? "frame_err" : "ready", bus.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    int         r;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h00};

    rst = 1'b0;
    wait_cycles(3);
    check("reset data", {23'd0, bus.data}, 32'h0);
    check("reset ready", {31'd0, bus.ready}, 32'h0);
    check("reset frame_err", {31'd0, bus.frame_err}, 32'h0);
    rst = 1'b1;
    wait_cycles(5);

    send_byte(8'hE0, 0, 0, "E0");
    send_byte(8'h75, 0, 0, "E0,75 make");
    send_byte(8'hE0, 0, 0, "E0");
    send_byte(8'hF0, 0, 0, "F0");
    send_byte(8'h75, 0, 0, "E0,F0,75 break");
    send_byte(8'hE0, 0, 0, "E0");
    send_byte(8'h75, 0, 0, "E0,75 make");
    send_byte(8'hF0, 0, 0, "F0");
    send_byte(8'h75, 0, 0, "F0,75 no-match break");
    send_byte(8'h1C, 1, 0, "1C bad parity");
    send_byte(8'h1C, 0, 1, "1C bad stop");

    // Stalled frame after an E0 prefix: abort must also drop the prefix.
    send_byte(8'hE0, 0, 0, "E0 before stall");
    sb.push_back('{1'b1, m_data});
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 6);
    wait_cycles(TO + 50);
    check("pending timeout", sb.size(), 0);
    send_byte(8'h1C, 0, 0, "1C after timeout");

    // Sub-filter glitches on ps2_clk with data low would look like start bits if accepted.
    for (int g = 0; g < 4; g++) begin
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      wait_cycles(FL - 1);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(30);
    end
    check("data after glitches", {23'd0, bus.data}, {23'd0, m_data});
    send_byte(8'h72, 0, 0, "72 after glitches");

    send_byte(8'hE0, 0, 0, "E0");
    send_byte(8'h74, 0, 0, "E0,74 make");
    send_bits({1'b1, ~^8'h6B, 8'h6B, 1'b0}, 4);
    rst = 1'b0;
    wait_cycles(3);
    check("mid-frame reset data", {23'd0, bus.data}, 32'h0);
    check("mid-frame reset ready", {31'd0, bus.ready}, 32'h0);
    m_data = 9'h000;
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_data = 1'b1;
    rst = 1'b1;
    wait_cycles(5);
    send_byte(8'h6B, 0, 0, "6B after reset");

    for (int t = 0; t < 4; t++) begin
      send_byte(8'hE0, 0, 0, "typematic E0");
      send_byte(8'h74, 0, 0, "typematic E0,74");
    end

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 7);
      b = (r == 7) ? 8'($urandom) : pool[r];
      r = $urandom_range(0, 15);
      send_byte(b, r == 0, r == 1, $sformatf("random %h", b));
    end

    wait_cycles(50);
    check("final pending", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
